mem_initiator: RTL and testbench
================================

Name: mem_initiator

Overview:
Master (initiator) end of the memory request/reply handshake protocol, used between a CPU load/store stage and a memory slave.
- Accepts one simple CPU access at a time.
- Drives the slave's read or write request channel.
- Waits for the matching reply and returns data and status to the CPU.
- Works with both slave styles: registered-reply slaves, and slaves whose reply is valid in the same cycle (always-valid).

Parameters:
ADDR_WIDTH, 64, byte address width.
DATA_WIDTH, 64, data bus width; must be a multiple of 8.
TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only when MEM_INITIATOR_TIMEOUT_EN is defined.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
cpu_req_valid  in  1  CPU access request.
cpu_req_ready  out  1  initiator can accept a request; high only in IDLE.
cpu_req_we  in  1  1 = write, 0 = read.
cpu_req_addr  in  ADDR_WIDTH  byte address, passed through unmodified.
cpu_req_wdata  in  DATA_WIDTH  write data.
cpu_req_wmask  in  DATA_WIDTH/8  byte enables.
cpu_resp_valid  out  1  one-cycle pulse when the access completes.
cpu_resp_rdata  out  DATA_WIDTH  read data, held until the next completion.
cpu_resp_err  out  1  reply status was not OKAY, or a timeout occurred; qualified by cpu_resp_valid.
r_request_valid / r_request_ready  out / in  1 / 1  read request handshake.
r_request_raddr  out  ADDR_WIDTH  read address.
r_reply_valid / r_reply_ready  in / out  1 / 1  read reply handshake.
r_reply_rdata  in  DATA_WIDTH  read data from the slave.
r_reply_rresp  in  2  read status: OKAY=2'b00, SLVERR=2'b10.
w_request_valid / w_request_ready  out / in  1 / 1  write request handshake.
w_request_waddr  out  ADDR_WIDTH  write address.
w_request_wdata  out  DATA_WIDTH  write data.
w_request_wmask  out  DATA_WIDTH/8  write byte enables.
w_reply_valid / w_reply_ready  in / out  1 / 1  write reply handshake.
w_reply_bresp  in  2  write status.

Behaviour:
- A handshake "fires" in a cycle where valid & ready are both high.
- States are IDLE, RREQ, RRESP, WREQ, WRESP, DONE. Reset value is IDLE.
- Reset values of outputs:
  - all valid outputs, both reply_ready outputs and cpu_resp_err = 0;
  - cpu_resp_rdata and all request address/data/mask registers = 0.
- IDLE:
  - cpu_req_ready = 1.
  - On cpu_req_valid, latch addr, wdata, wmask and we into request registers.
  - Go to WREQ if we = 1, otherwise RREQ.
- RREQ / WREQ:
  - The matching request_valid = 1. Request bits come from the latched registers and stay stable until the handshake fires.
  - On fire, go to RRESP / WRESP.
- RRESP / WRESP:
  - The matching reply_ready = 1.
  - A reply is never accepted in the cycle its request fires; minimum latency is request fire + 1 cycle.
  - On reply fire, capture rdata (reads only) and set err = (resp != 2'b00). Go to DONE.
- DONE:
  - cpu_resp_valid = 1 for exactly one cycle; next state is IDLE.
  - Minimum latency from CPU accept to cpu_resp_valid is 3 cycles.
- Exclusivity: the r and w channels are never active together, and request_valid is never high outside RREQ/WREQ.
- Replies arriving outside RRESP/WRESP are ignored (reply_ready = 0), so always-valid slaves are safe.
- Writes leave cpu_resp_rdata unchanged.
- cpu_req_* inputs are ignored outside IDLE; the CPU must hold its request until cpu_req_ready.
- rst asserted mid-transaction: next cycle is IDLE with all outputs at reset values, and no cpu_resp_valid is produced for the aborted access.

Optional Feature:
MEM_INITIATOR_TIMEOUT_EN
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to RREQ/WREQ and increments every cycle spent in RREQ/WREQ/RRESP/WRESP.
  - When it reaches TIMEOUT_CYCLES, go to DONE with cpu_resp_err = 1 and rdata unchanged, and drop all valid/ready outputs.
- Undefined: no counter; the initiator waits indefinitely.

Test Plan:
- Read with a registered slave: read addr 0x18; r_request_ready = 1; r_reply_valid one cycle later with rdata 0xDEADBEEF_CAFEF00D, rresp 0 → r_request_raddr = 0x18; cpu_resp_valid pulses once with that rdata; err = 0; latency 3 cycles.
- Write with backpressure: write addr 0x20, wdata 0x1122334455667788, wmask 0x0F; w_request_ready held low for 4 cycles → waddr/wdata/wmask stable throughout; exactly one fire; bresp 0 → err = 0.
- Always-valid slave: all readies and reply_valids tied to 1, back-to-back reads of 0x0 then 0x8 → each completes in 3 cycles; no reply is taken in a request-fire cycle.
- Error reply: read with rresp 2'b10 → cpu_resp_valid with cpu_resp_err = 1.
- Reset mid-operation: assert rst during WRESP → next cycle all valid/ready outputs = 0, cpu_req_ready = 1, no cpu_resp_valid.
- Timeout (macro defined, TIMEOUT_CYCLES = 16): r_reply_valid never asserted → cpu_resp_valid with err = 1 exactly 16 cycles after entering RREQ.

Source files
------------

// File: rtl/mem_initiator.sv
// mem_initiator: initiator end of the memory request/reply handshake.
// It takes one CPU access at a time and issues it on the read or the write
// request channel. It then waits for the matching reply and returns the data
// and status to the CPU as a one-cycle completion pulse.
// Every handshake output comes from a flop, and that flop is loaded from the
// decoded next state. This means replies from always-valid slaves are only
// accepted while the initiator is actually waiting for them.
// Optional build macro: MEM_INITIATOR_TIMEOUT_EN adds a watchdog. The watchdog
// ends a stalled access after TIMEOUT_CYCLES cycles and reports an error.
module mem_initiator #(
   parameter int unsigned ADDR_WIDTH     = 64,
   parameter int unsigned DATA_WIDTH     = 64,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   // CPU side
   input  logic                      cpu_req_valid,
   output logic                      cpu_req_ready,
   input  logic                      cpu_req_we,
   input  logic [ADDR_WIDTH-1:0]     cpu_req_addr,
   input  logic [DATA_WIDTH-1:0]     cpu_req_wdata,
   input  logic [DATA_WIDTH/8-1:0]   cpu_req_wmask,
   output logic                      cpu_resp_valid,
   output logic [DATA_WIDTH-1:0]     cpu_resp_rdata,
   output logic                      cpu_resp_err,
   // read channel
   output logic                      r_request_valid,
   input  logic                      r_request_ready,
   output logic [ADDR_WIDTH-1:0]     r_request_raddr,
   input  logic                      r_reply_valid,
   output logic                      r_reply_ready,
   input  logic [DATA_WIDTH-1:0]     r_reply_rdata,
   input  logic [1:0]                r_reply_rresp,
   // write channel
   output logic                      w_request_valid,
   input  logic                      w_request_ready,
   output logic [ADDR_WIDTH-1:0]     w_request_waddr,
   output logic [DATA_WIDTH-1:0]     w_request_wdata,
   output logic [DATA_WIDTH/8-1:0]   w_request_wmask,
   input  logic                      w_reply_valid,
   output logic                      w_reply_ready,
   input  logic [1:0]                w_reply_bresp
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam logic [1:0]  RESP_OKAY  = 2'b00;

   // Elaboration-time sanity checks on the configuration.
   generate
      if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
         $error("mem_initiator: DATA_WIDTH must be a multiple of 8");
      end
      if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
         $error("mem_initiator: TIMEOUT_CYCLES must be at least 1");
      end
   endgenerate

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RREQ  = 3'd1,
      ST_RRESP = 3'd2,
      ST_WREQ  = 3'd3,
      ST_WRESP = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   state_e                  state_q, state_d;

   // latched copy of the accepted CPU request
   logic [ADDR_WIDTH-1:0]   req_addr_q,  req_addr_d;
   logic [DATA_WIDTH-1:0]   req_wdata_q, req_wdata_d;
   logic [STRB_WIDTH-1:0]   req_wmask_q, req_wmask_d;

   // completion results
   logic [DATA_WIDTH-1:0]   cpu_resp_rdata_q, cpu_resp_rdata_d;
   logic                    cpu_resp_err_q,   cpu_resp_err_d;

   // handshake output flops
   logic                    cpu_req_ready_q,   cpu_req_ready_d;
   logic                    cpu_resp_valid_q,  cpu_resp_valid_d;
   logic                    r_request_valid_q, r_request_valid_d;
   logic                    r_reply_ready_q,   r_reply_ready_d;
   logic                    w_request_valid_q, w_request_valid_d;
   logic                    w_reply_ready_q,   w_reply_ready_d;

   // handshake fire strobes
   logic                    r_req_fire_s;
   logic                    r_rep_fire_s;
   logic                    w_req_fire_s;
   logic                    w_rep_fire_s;
   logic                    waiting_s;

`ifdef MEM_INITIATOR_TIMEOUT_EN
   localparam int unsigned            CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_WIDTH-1:0]   CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]   CNT_ZERO  = CNT_WIDTH'(0);

   logic [CNT_WIDTH-1:0]    tmo_cnt_q, tmo_cnt_d;
`endif

   // Fire strobes: valid & ready on each channel, using the output flops.
   always_comb begin
      r_req_fire_s = r_request_valid_q & r_request_ready;
      r_rep_fire_s = r_reply_ready_q   & r_reply_valid;
      w_req_fire_s = w_request_valid_q & w_request_ready;
      w_rep_fire_s = w_reply_ready_q   & w_reply_valid;
      waiting_s    = (state_q == ST_RREQ)  || (state_q == ST_RRESP) ||
                     (state_q == ST_WREQ)  || (state_q == ST_WRESP);
   end

   // Next-state logic, request latching and reply capture.
   always_comb begin
      state_d          = state_q;
      req_addr_d       = req_addr_q;
      req_wdata_d      = req_wdata_q;
      req_wmask_d      = req_wmask_q;
      cpu_resp_rdata_d = cpu_resp_rdata_q;
      cpu_resp_err_d   = cpu_resp_err_q;
`ifdef MEM_INITIATOR_TIMEOUT_EN
      tmo_cnt_d        = tmo_cnt_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (cpu_req_valid) begin
               req_addr_d  = cpu_req_addr;
               req_wdata_d = cpu_req_wdata;
               req_wmask_d = cpu_req_wmask;
               state_d     = cpu_req_we ? ST_WREQ : ST_RREQ;
            end else begin
               state_d     = ST_IDLE;
            end
         end
         ST_RREQ: begin
            if (r_req_fire_s) begin
               state_d = ST_RRESP;
            end else begin
               state_d = ST_RREQ;
            end
         end
         ST_RRESP: begin
            if (r_rep_fire_s) begin
               cpu_resp_rdata_d = r_reply_rdata;
               cpu_resp_err_d   = (r_reply_rresp != RESP_OKAY);
               state_d          = ST_DONE;
            end else begin
               state_d          = ST_RRESP;
            end
         end
         ST_WREQ: begin
            if (w_req_fire_s) begin
               state_d = ST_WRESP;
            end else begin
               state_d = ST_WREQ;
            end
         end
         ST_WRESP: begin
            // writes leave the returned read data untouched
            if (w_rep_fire_s) begin
               cpu_resp_err_d = (w_reply_bresp != RESP_OKAY);
               state_d        = ST_DONE;
            end else begin
               state_d        = ST_WRESP;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

`ifdef MEM_INITIATOR_TIMEOUT_EN
      // The count holds 0 in the first request cycle. Once it reaches the
      // limit, the access has spent TIMEOUT_CYCLES cycles outstanding. A reply
      // that fires in that same cycle wins and keeps its own status.
      if (waiting_s) begin
         tmo_cnt_d = tmo_cnt_q + CNT_ONE;
         if ((tmo_cnt_d == CNT_LIMIT) && (state_d != ST_DONE)) begin
            state_d        = ST_DONE;
            cpu_resp_err_d = 1'b1;
         end else begin
            state_d        = state_d;
         end
      end else begin
         tmo_cnt_d = CNT_ZERO;
      end
`endif
   end

   // Handshake outputs decoded from the next state so they are registered.
   always_comb begin
      cpu_req_ready_d   = (state_d == ST_IDLE);
      cpu_resp_valid_d  = (state_d == ST_DONE);
      r_request_valid_d = (state_d == ST_RREQ);
      r_reply_ready_d   = (state_d == ST_RRESP);
      w_request_valid_d = (state_d == ST_WREQ);
      w_reply_ready_d   = (state_d == ST_WRESP);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= ST_IDLE;
         req_addr_q        <= {ADDR_WIDTH{1'b0}};
         req_wdata_q       <= {DATA_WIDTH{1'b0}};
         req_wmask_q       <= {STRB_WIDTH{1'b0}};
         cpu_resp_rdata_q  <= {DATA_WIDTH{1'b0}};
         cpu_resp_err_q    <= 1'b0;
         cpu_req_ready_q   <= 1'b1;
         cpu_resp_valid_q  <= 1'b0;
         r_request_valid_q <= 1'b0;
         r_reply_ready_q   <= 1'b0;
         w_request_valid_q <= 1'b0;
         w_reply_ready_q   <= 1'b0;
      end else begin
         state_q           <= state_d;
         req_addr_q        <= req_addr_d;
         req_wdata_q       <= req_wdata_d;
         req_wmask_q       <= req_wmask_d;
         cpu_resp_rdata_q  <= cpu_resp_rdata_d;
         cpu_resp_err_q    <= cpu_resp_err_d;
         cpu_req_ready_q   <= cpu_req_ready_d;
         cpu_resp_valid_q  <= cpu_resp_valid_d;
         r_request_valid_q <= r_request_valid_d;
         r_reply_ready_q   <= r_reply_ready_d;
         w_request_valid_q <= w_request_valid_d;
         w_reply_ready_q   <= w_reply_ready_d;
      end
   end

`ifdef MEM_INITIATOR_TIMEOUT_EN
   // Watchdog counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt_q <= CNT_ZERO;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
`endif

   assign cpu_req_ready   = cpu_req_ready_q;
   assign cpu_resp_valid  = cpu_resp_valid_q;
   assign cpu_resp_rdata  = cpu_resp_rdata_q;
   assign cpu_resp_err    = cpu_resp_err_q;
   assign r_request_valid = r_request_valid_q;
   assign r_request_raddr = req_addr_q;
   assign r_reply_ready   = r_reply_ready_q;
   assign w_request_valid = w_request_valid_q;
   assign w_request_waddr = req_addr_q;
   assign w_request_wdata = req_wdata_q;
   assign w_request_wmask = req_wmask_q;
   assign w_reply_ready   = w_reply_ready_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Testbench for mem_initiator. It uses directed scenarios plus randomized
// accesses against a transaction-level slave/CPU model.
module tb_mem_initiator;

   localparam int AW = 64;
   localparam int DW = 64;
   localparam int SW = DW / 8;

   logic           clk = 1'b0;
   logic           rst;
   logic           cpu_req_valid, cpu_req_ready, cpu_req_we;
   logic [AW-1:0]  cpu_req_addr;
   logic [DW-1:0]  cpu_req_wdata;
   logic [SW-1:0]  cpu_req_wmask;
   logic           cpu_resp_valid, cpu_resp_err;
   logic [DW-1:0]  cpu_resp_rdata;
   logic           r_request_valid, r_request_ready, r_reply_valid, r_reply_ready;
   logic [AW-1:0]  r_request_raddr;
   logic [DW-1:0]  r_reply_rdata;
   logic [1:0]     r_reply_rresp;
   logic           w_request_valid, w_request_ready, w_reply_valid, w_reply_ready;
   logic [AW-1:0]  w_request_waddr;
   logic [DW-1:0]  w_request_wdata;
   logic [SW-1:0]  w_request_wmask;
   logic [1:0]     w_reply_bresp;

   int n_cmp = 0;
   int n_bad = 0;

   // model state: last read data the CPU should see, plus slave memory
   logic [DW-1:0]  exp_rdata;
   logic [DW-1:0]  mem_model [logic [AW-1:0]];

   always #5 clk = ~clk;

   mem_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
      .cpu_req_we(cpu_req_we), .cpu_req_addr(cpu_req_addr),
      .cpu_req_wdata(cpu_req_wdata), .cpu_req_wmask(cpu_req_wmask),
      .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
      .cpu_resp_err(cpu_resp_err),
      .r_request_valid(r_request_valid), .r_request_ready(r_request_ready),
      .r_request_raddr(r_request_raddr),
      .r_reply_valid(r_reply_valid), .r_reply_ready(r_reply_ready),
      .r_reply_rdata(r_reply_rdata), .r_reply_rresp(r_reply_rresp),
      .w_request_valid(w_request_valid), .w_request_ready(w_request_ready),
      .w_request_waddr(w_request_waddr), .w_request_wdata(w_request_wdata),
      .w_request_wmask(w_request_wmask),
      .w_reply_valid(w_reply_valid), .w_reply_ready(w_reply_ready),
      .w_reply_bresp(w_reply_bresp)
   );

   function automatic logic [DW-1:0] slave_read(input logic [AW-1:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return a ^ 64'hA5A5_0000_5A5A_FFFF;
   endfunction

   function automatic void slave_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                       input logic [SW-1:0] m);
      logic [DW-1:0] v;
      v = slave_read(a);
      for (int b = 0; b < SW; b++) if (m[b]) v[b*8 +: 8] = d[b*8 +: 8];
      mem_model[a] = v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_slave(input logic on);
      r_request_ready = on;
      r_reply_valid   = on;
      w_request_ready = on;
      w_reply_valid   = on;
   endtask

   // One CPU access with an emulated slave. In registered mode, request
   // ready rises after rq_dly request cycles and the reply arrives rp_dly
   // cycles into the reply phase. In always-on mode every ready/valid is tied
   // high. viol counts protocol breaches seen on the way.
   task automatic run_access(input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [SW-1:0] wmask,
                             input int rq_dly, input int rp_dly, input logic always_on,
                             input logic [1:0] resp, input logic [DW-1:0] rdata_in,
                             output logic [DW-1:0] rdata_o, output logic err_o,
                             output int lat, output int viol);
      int   phase, wcnt, rcnt;
      logic req_v, rep_r, oth_v, oth_r, rdy, rv;
      viol = 0; lat = -1; rdata_o = '0; err_o = 1'b0;
      phase = 0; wcnt = 0; rcnt = 0;
      r_reply_rdata = rdata_in; r_reply_rresp = resp; w_reply_bresp = resp;
      set_slave(always_on);
      cpu_req_valid = 1'b1; cpu_req_we = we; cpu_req_addr = addr;
      cpu_req_wdata = wdata; cpu_req_wmask = wmask;
      if (cpu_req_ready !== 1'b1) viol++;
      tick();
      // garbage on the CPU inputs must be ignored while busy
      cpu_req_valid = 1'b0;
      cpu_req_we    = 1'($urandom);
      cpu_req_addr  = {$urandom, $urandom};
      cpu_req_wdata = {$urandom, $urandom};
      cpu_req_wmask = 8'($urandom);
      for (int c = 1; c <= 200; c++) begin
         req_v = we ? w_request_valid : r_request_valid;
         rep_r = we ? w_reply_ready   : r_reply_ready;
         oth_v = we ? r_request_valid : w_request_valid;
         oth_r = we ? r_reply_ready   : w_reply_ready;
         if (cpu_resp_valid === 1'b1) begin
            lat = c; rdata_o = cpu_resp_rdata; err_o = cpu_resp_err;
            break;
         end
         if (oth_v !== 1'b0 || oth_r !== 1'b0 || cpu_req_ready !== 1'b0) viol++;
         if (phase == 0) begin
            if (req_v !== 1'b1 || rep_r !== 1'b0) viol++;
            if (we) begin
               if (w_request_waddr !== addr || w_request_wdata !== wdata ||
                   w_request_wmask !== wmask) viol++;
            end else begin
               if (r_request_raddr !== addr) viol++;
            end
            rdy = always_on || (wcnt >= rq_dly);
            if (!always_on) begin
               if (we) w_request_ready = rdy; else r_request_ready = rdy;
            end
            if (req_v && rdy) phase = 1;
            wcnt++;
         end else if (phase == 1) begin
            if (req_v !== 1'b0 || rep_r !== 1'b1) viol++;
            rv = always_on || (rcnt >= rp_dly);
            if (!always_on) begin
               r_request_ready = 1'b0; w_request_ready = 1'b0;
               if (we) w_reply_valid = rv; else r_reply_valid = rv;
            end
            if (rep_r && rv) phase = 2;
            rcnt++;
         end else begin
            viol++;   // reply was taken but no completion followed
         end
         tick();
      end
      if (!always_on) set_slave(1'b0);
      if (lat >= 0) begin
         tick();
         if (cpu_resp_valid !== 1'b0 || cpu_req_ready !== 1'b1) viol++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = '0;
      cpu_req_wdata = '0; cpu_req_wmask = '0; set_slave(1'b0);
      r_reply_rdata = '0; r_reply_rresp = 2'b00; w_reply_bresp = 2'b00;
      tick(); tick();
      n_cmp++;
      if ({cpu_req_ready, cpu_resp_valid, cpu_resp_err} !== 3'b100) begin
         n_bad++; $display("FAIL reset_cpu: got %b expected 100", {cpu_req_ready, cpu_resp_valid, cpu_resp_err});
      end
      n_cmp++;
      if ({r_request_valid, r_reply_ready, w_request_valid, w_reply_ready} !== 4'b0000) begin
         n_bad++; $display("FAIL reset_chan: got %b expected 0000",
                           {r_request_valid, r_reply_ready, w_request_valid, w_reply_ready});
      end
      n_cmp++;
      if (cpu_resp_rdata !== 64'h0 || r_request_raddr !== 64'h0 || w_request_waddr !== 64'h0 ||
          w_request_wdata !== 64'h0 || w_request_wmask !== 8'h0) begin
         n_bad++; $display("FAIL reset_regs: got rdata=%h raddr=%h waddr=%h wdata=%h wmask=%h expected all zero",
                           cpu_resp_rdata, r_request_raddr, w_request_waddr, w_request_wdata, w_request_wmask);
      end
      exp_rdata = 64'h0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_read_registered();
      logic [DW-1:0] rd; logic er; int lat, viol;
      run_access(1'b0, 64'h18, 64'h0, 8'h0, 0, 0, 1'b0, 2'b00, 64'hDEADBEEF_CAFEF00D,
                 rd, er, lat, viol);
      exp_rdata = 64'hDEADBEEF_CAFEF00D;
      n_cmp++;
      if (rd !== exp_rdata || er !== 1'b0) begin
         n_bad++; $display("FAIL read_data: got %h/%b expected %h/0", rd, er, exp_rdata);
      end
      n_cmp++;
      if (lat != 3 || viol != 0) begin
         n_bad++; $display("FAIL read_latency: got lat=%0d viol=%0d expected 3/0", lat, viol);
      end
   endtask

   task automatic test_write_backpressure();
      logic [DW-1:0] rd; logic er; int lat, viol;
      run_access(1'b1, 64'h20, 64'h1122334455667788, 8'h0F, 4, 1, 1'b0, 2'b00, 64'h0,
                 rd, er, lat, viol);
      slave_write(64'h20, 64'h1122334455667788, 8'h0F);
      n_cmp++;
      if (rd !== exp_rdata || er !== 1'b0) begin
         n_bad++; $display("FAIL write_result: got %h/%b expected %h/0", rd, er, exp_rdata);
      end
      n_cmp++;
      if (lat != 8 || viol != 0) begin
         n_bad++; $display("FAIL write_bp: got lat=%0d viol=%0d expected 8/0", lat, viol);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] rd, exp_d; logic er; int lat, viol;
      for (int i = 0; i < 2; i++) begin
         exp_d = slave_read(64'(i * 8));
         run_access(1'b0, 64'(i * 8), 64'h0, 8'h0, 0, 0, 1'b1, 2'b00, exp_d,
                    rd, er, lat, viol);
         exp_rdata = exp_d;
         n_cmp++;
         if (rd !== exp_d || er !== 1'b0 || lat != 3 || viol != 0) begin
            n_bad++; $display("FAIL b2b_read%0d: got %h/%b lat=%0d viol=%0d expected %h/0 lat=3 viol=0",
                              i, rd, er, lat, viol, exp_d);
         end
      end
      set_slave(1'b0);
   endtask

   task automatic test_error_reply();
      logic [DW-1:0] rd; logic er; int lat, viol;
      run_access(1'b0, 64'h40, 64'h0, 8'h0, 1, 2, 1'b0, 2'b10, 64'h0BAD_0BAD_0BAD_0BAD,
                 rd, er, lat, viol);
      exp_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
      n_cmp++;
      if (er !== 1'b1 || lat != 6 || viol != 0) begin
         n_bad++; $display("FAIL err_read: got err=%b lat=%0d viol=%0d expected 1/6/0", er, lat, viol);
      end
      run_access(1'b1, 64'h48, 64'h55, 8'hFF, 0, 0, 1'b0, 2'b10, 64'h0, rd, er, lat, viol);
      n_cmp++;
      if (er !== 1'b1 || rd !== exp_rdata || lat != 3 || viol != 0) begin
         n_bad++; $display("FAIL err_write: got err=%b rdata=%h lat=%0d viol=%0d expected 1/%h/3/0",
                           er, rd, lat, viol, exp_rdata);
      end
   endtask

   task automatic test_reset_mid();
      logic seen;
      cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cpu_req_addr = 64'h60;
      cpu_req_wdata = 64'h1234; cpu_req_wmask = 8'hFF; w_reply_bresp = 2'b00;
      tick();                      // now WREQ
      cpu_req_valid = 1'b0; w_request_ready = 1'b1;
      tick();                      // now WRESP
      w_request_ready = 1'b0;
      n_cmp++;
      if (w_reply_ready !== 1'b1) begin
         n_bad++; $display("FAIL mid_wresp: got w_reply_ready=%b expected 1", w_reply_ready);
      end
      rst = 1'b1; w_reply_valid = 1'b1;
      tick();
      rst = 1'b0; w_reply_valid = 1'b0;
      exp_rdata = 64'h0;
      n_cmp++;
      if ({cpu_req_ready, cpu_resp_valid, r_request_valid, r_reply_ready, w_request_valid, w_reply_ready} !== 6'b100000 ||
          w_request_waddr !== 64'h0 || cpu_resp_rdata !== 64'h0) begin
         n_bad++; $display("FAIL mid_reset: got ctl=%b waddr=%h rdata=%h expected 100000/0/0",
                           {cpu_req_ready, cpu_resp_valid, r_request_valid, r_reply_ready, w_request_valid, w_reply_ready},
                           w_request_waddr, cpu_resp_rdata);
      end
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (cpu_resp_valid !== 1'b0) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_bad++; $display("FAIL mid_noresp: got resp_valid after abort=%b expected 0", seen);
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] rd, rin, wd, exp_d; logic er, we, ao; logic [AW-1:0] a;
      logic [SW-1:0] m; logic [1:0] rsp; int rq, rp, lat, viol, exp_lat;
      for (int i = 0; i < 40; i++) begin
         we  = 1'($urandom);
         a   = 64'({$urandom_range(0, 15), 3'b000});
         wd  = {$urandom, $urandom};
         m   = 8'($urandom);
         rq  = $urandom_range(0, 4);
         rp  = $urandom_range(0, 4);
         ao  = ($urandom_range(0, 7) == 0);
         rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         rin = slave_read(a);
         run_access(we, a, wd, m, rq, rp, ao, rsp, rin, rd, er, lat, viol);
         if (we) begin
            if (rsp == 2'b00) slave_write(a, wd, m);
         end else begin
            exp_rdata = rin;
         end
         exp_d   = exp_rdata;
         exp_lat = ao ? 3 : 3 + rq + rp;
         n_cmp++;
         if (rd !== exp_d) begin
            n_bad++; $display("FAIL rand%0d_rdata: got %h expected %h", i, rd, exp_d);
         end
         n_cmp++;
         if (er !== (rsp != 2'b00)) begin
            n_bad++; $display("FAIL rand%0d_err: got %b expected %b", i, er, (rsp != 2'b00));
         end
         n_cmp++;
         if (lat != exp_lat || viol != 0) begin
            n_bad++; $display("FAIL rand%0d_proto: got lat=%0d viol=%0d expected %0d/0", i, lat, viol, exp_lat);
         end
         if (ao) set_slave(1'b0);
      end
   endtask

`ifdef MEM_INITIATOR_TIMEOUT_EN
   task automatic test_timeout();
      logic [DW-1:0] rd; logic er; int lat, viol;
      run_access(1'b0, 64'h80, 64'h0, 8'h0, 2, 1000, 1'b0, 2'b00, 64'h77, rd, er, lat, viol);
      n_cmp++;
      if (lat != 17 || er !== 1'b1 || rd !== exp_rdata || viol != 0) begin
         n_bad++; $display("FAIL timeout: got lat=%0d err=%b rdata=%h viol=%0d expected 17/1/%h/0",
                           lat, er, rd, viol, exp_rdata);
      end
   endtask
`else
   task automatic test_long_wait();
      logic [DW-1:0] rd; logic er; int lat, viol;
      run_access(1'b0, 64'h88, 64'h0, 8'h0, 0, 40, 1'b0, 2'b00, 64'h99, rd, er, lat, viol);
      exp_rdata = 64'h99;
      n_cmp++;
      if (lat != 43 || er !== 1'b0 || rd !== 64'h99 || viol != 0) begin
         n_bad++; $display("FAIL long_wait: got lat=%0d err=%b rdata=%h viol=%0d expected 43/0/99/0",
                           lat, er, rd, viol);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_read_registered();
      test_write_backpressure();
      test_back_to_back();
      test_error_reply();
      test_reset_mid();
      test_random();
`ifdef MEM_INITIATOR_TIMEOUT_EN
      test_timeout();
`else
      test_long_wait();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
